// File: rtl/seg7_scan_pkg.sv
// Shared constants for the 4-digit multiplexed hex display: segment table,
// digit-index encoding and pin-polarity helpers.
package seg7_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;

  typedef enum logic [1:0] {D0, D1, D2, D3} idx_t;

  // Active-high GFEDCBA patterns; element 0 is the rightmost entry
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [NUM_DIGITS-1:0] en_pol(input logic [NUM_DIGITS-1:0] en_ah,
                                                   input logic act_low);
    return act_low ? ~en_ah : en_ah;
  endfunction

  function automatic logic [SEG_W-1:0] seg_pol(input logic [SEG_W-1:0] seg_ah,
                                               input logic act_low);
    return act_low ? ~seg_ah : seg_ah;
  endfunction

endpackage

// File: rtl/seg7_scan_hex7_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex7_decode
  import seg7_scan_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit hex display driver with valid/ready input, frame-boundary
// swap of the shown value, per-slot dead time and optional leading-zero blanking.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned BLANK_CYC   = 50,
  parameter bit          EN_ACT_LOW  = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] ds_en,
  output logic [SEG_W-1:0]      ds_seg
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0]      cnt_q;
  idx_t                  idx_q, idx_d;
  logic                  wrap, boundary;
  logic [DATA_W-1:0]     pend_reg, disp_reg;
  logic                  pend_full;
  logic                  lz_q;
  logic [NUM_DIGITS-1:0] en_onehot_c;
  logic [NIB_W-1:0]      nib_c;
  logic                  blank_c;
  logic [SEG_W-1:0]      seg_dec_c;
  logic                  zero3, zero2, zero1;

  assign wrap     = (cnt_q == CNT_W'(PRESCALE - 1));
  assign boundary = wrap && (idx_q == D3);

  // Slot prescaler
  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (wrap) cnt_q <= '0;
    else           cnt_q <= cnt_q + CNT_W'(1);
  end

  // Digit index state register
  always_ff @(posedge clk) begin
    if (rst) idx_q <= D0;
    else     idx_q <= idx_d;
  end

  // Digit index next state: advance once per slot
  always_comb begin
    idx_d = idx_q;
    if (wrap) begin
      case (idx_q)
        D0: idx_d = D1;
        D1: idx_d = D2;
        D2: idx_d = D3;
        D3: idx_d = D0;
        default: idx_d = D0;
      endcase
    end
  end

  // Digit index output: one-hot enable of the current digit
  always_comb begin
    en_onehot_c = '0;
    case (idx_q)
      D0: en_onehot_c = 4'b0001;
      D1: en_onehot_c = 4'b0010;
      D2: en_onehot_c = 4'b0100;
      D3: en_onehot_c = 4'b1000;
      default: en_onehot_c = '0;
    endcase
  end

  // Pending/display pair; ready tracks the pending slot being free
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg   <= '0;
      pend_full  <= 1'b0;
      disp_reg   <= '0;
      data_ready <= 1'b1;
    end else if (boundary && pend_full) begin
      disp_reg   <= pend_reg;
      pend_full  <= 1'b0;
      data_ready <= 1'b1;
    end else if (data_valid && data_ready) begin
      pend_reg   <= data;
      pend_full  <= 1'b1;
      data_ready <= 1'b0;
    end
  end

  // Blanking mode is latched per slot so a digit never changes mid-slot
  always_ff @(posedge clk) begin
    if (rst)               lz_q <= 1'b0;
    else if (cnt_q == '0)  lz_q <= blank_lz;
  end

  assign zero3 = (disp_reg[15:12] == 4'h0);
  assign zero2 = zero3 && (disp_reg[11:8] == 4'h0);
  assign zero1 = zero2 && (disp_reg[7:4] == 4'h0);

  // Nibble select and leading-zero blank for the current digit
  always_comb begin
    nib_c   = disp_reg[3:0];
    blank_c = 1'b0;
    case (idx_q)
      D0: nib_c = disp_reg[3:0];
      D1: begin nib_c = disp_reg[7:4];   blank_c = lz_q && zero1; end
      D2: begin nib_c = disp_reg[11:8];  blank_c = lz_q && zero2; end
      D3: begin nib_c = disp_reg[15:12]; blank_c = lz_q && zero3; end
      default: nib_c = disp_reg[3:0];
    endcase
  end

  hex7_decode u_dec (
    .nib   (nib_c),
    .seg_c (seg_dec_c)
  );

  // Pin registers: dead time at slot start, then the selected digit
  always_ff @(posedge clk) begin
    if (rst || (cnt_q < CNT_W'(BLANK_CYC))) begin
      ds_en  <= en_pol('0, EN_ACT_LOW);
      ds_seg <= seg_pol('0, SEG_ACT_LOW);
    end else begin
      ds_en  <= en_pol(en_onehot_c, EN_ACT_LOW);
      ds_seg <= seg_pol(blank_c ? '0 : seg_dec_c, SEG_ACT_LOW);
    end
  end

endmodule
